// File: rtl/posit8_decode_if.sv
// Valid/ready handshake bundle for the posit8 decode pipeline: raw posit in, decoded word out.
interface posit8_decode_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_posit;
  logic       out_valid;
  logic       out_ready;
  logic       out_sign;
  logic       out_zero;
  logic       out_nar;
  logic [8:0] out_eposit;

  modport slave (
    input  in_valid, in_posit, out_ready,
    output in_ready, out_valid, out_sign, out_zero, out_nar, out_eposit
  );

  modport master (
    output in_valid, in_posit, out_ready,
    input  in_ready, out_valid, out_sign, out_zero, out_nar, out_eposit
  );
endinterface

// File: rtl/posit8_decode_pipe.sv
// Two-stage posit8 (es=0) decode front end: sign/abs/special detect, then regime shift to eposit.
// Optional special-value counters are enabled by defining POSIT_DECODE_STATS_EN.

// Regime shifter: positive posit magnitude -> {biased exponent k+6, 5-bit fraction}.
module regimeshifter_with_exp_8bit (
  input  logic [7:0] posit,
  output logic [8:0] eposit
);
  logic [2:0] run;
  logic       done;
  logic [6:0] rest;
  logic [4:0] frac;
  logic [1:0] unused_lsb;
  logic       unused_msb;
  logic [3:0] expo;

  assign unused_msb = posit[7];

  // Length of the leading run of identical bits after the sign position.
  always_comb begin
    run  = 3'd0;
    done = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      if (!done && (posit[i] == posit[6])) run = run + 3'd1;
      else done = 1'b1;
    end
  end

  assign expo = posit[6] ? (4'(run) + 4'd5) : (4'd6 - 4'(run));
  // Drop the regime and its terminator; what remains is the left-aligned fraction.
  assign rest = posit[6:0] << (4'(run) + 4'd1);
  assign {frac, unused_lsb} = rest;
  assign eposit = {expo, frac};
endmodule

module posit8_decode_pipe #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  posit8_decode_if.slave       bus
`ifdef POSIT_DECODE_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] zero_count,
  output logic [CNT_WIDTH-1:0] nar_count
`endif
);
  if (CNT_WIDTH < 1) begin : g_bad_cnt_width
    $error("CNT_WIDTH must be at least 1");
  end

  logic       v1;
  logic       sign1;
  logic       zero1;
  logic       nar1;
  logic [6:0] mag1;
  logic       e1;
  logic       e2;
  logic [7:0] neg;
  logic       in_zero;
  logic       in_nar;
  logic [8:0] shift_eposit;

  assign e2           = !bus.out_valid || bus.out_ready;
  assign e1           = !v1 || e2;
  assign bus.in_ready = e1;

  assign neg     = 8'(~bus.in_posit + 8'd1);
  assign in_zero = (bus.in_posit == 8'h00);
  assign in_nar  = (bus.in_posit == 8'h80);

  // Stage 1: sign, special flags and absolute value.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      sign1 <= 1'b0;
      zero1 <= 1'b0;
      nar1  <= 1'b0;
      mag1  <= 7'd0;
    end else if (e1) begin
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        sign1 <= bus.in_posit[7];
        zero1 <= in_zero;
        nar1  <= in_nar;
        // NaR negates to itself; force its magnitude to zero instead.
        if (in_nar)               mag1 <= 7'd0;
        else if (bus.in_posit[7]) mag1 <= neg[6:0];
        else                      mag1 <= bus.in_posit[6:0];
      end
    end
  end

  regimeshifter_with_exp_8bit u_shift (
    .posit  ({1'b0, mag1}),
    .eposit (shift_eposit)
  );

  // Stage 2: output register; shifter result discarded for zero and NaR.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid  <= 1'b0;
      bus.out_sign   <= 1'b0;
      bus.out_zero   <= 1'b0;
      bus.out_nar    <= 1'b0;
      bus.out_eposit <= 9'd0;
    end else if (e2) begin
      bus.out_valid <= v1;
      if (v1) begin
        bus.out_sign   <= sign1 || nar1;
        bus.out_zero   <= zero1;
        bus.out_nar    <= nar1;
        bus.out_eposit <= (zero1 || nar1) ? 9'd0 : shift_eposit;
      end
    end
  end

`ifdef POSIT_DECODE_STATS_EN
  // Saturating counts of accepted zero and NaR inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_count <= '0;
      nar_count  <= '0;
    end else if (bus.in_valid && e1) begin
      if (in_zero && (zero_count != {CNT_WIDTH{1'b1}}))
        zero_count <= zero_count + CNT_WIDTH'(1);
      if (in_nar && (nar_count != {CNT_WIDTH{1'b1}}))
        nar_count <= nar_count + CNT_WIDTH'(1);
    end
  end
`endif
endmodule

// File: tb/tb_posit8_decode_pipe.sv
// Randomized scoreboard bench for posit8_decode_pipe with an encode-side posit reference table.
module tb_posit8_decode_pipe;
`ifdef POSIT_DECODE_STATS_EN
  localparam int unsigned CW = 4;
`else
  localparam int unsigned CW = 16;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  posit8_decode_if bus ();

`ifdef POSIT_DECODE_STATS_EN
  logic [CW-1:0] zero_count;
  logic [CW-1:0] nar_count;
`endif

  posit8_decode_pipe #(.CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus)
`ifdef POSIT_DECODE_STATS_EN
    ,
    .zero_count (zero_count),
    .nar_count  (nar_count)
`endif
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  bit          lat_chk = 1'b0;
  logic [8:0]  tab [128];
  logic [11:0] q [$];
  int          qc [$];
  bit          held = 1'b0;
  logic [11:0] held_word;
  int          m_zero = 0;
  int          m_nar  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Build the table by encoding every (k, fraction) pair into its posit bit pattern.
  task automatic build_tab();
    for (int i = 0; i < 128; i++) tab[i] = 9'd0;
    for (int k = -6; k <= 6; k++) begin
      int len, rv, nf;
      if (k == 6) begin
        len = 7; rv = 127;
      end else if (k >= 0) begin
        len = k + 2; rv = ((1 << (k + 1)) - 1) << 1;
      end else begin
        len = 1 - k; rv = 1;
      end
      nf = 7 - len;
      for (int f = 0; f < (1 << nf); f++)
        tab[(rv << nf) | f] = 9'(((k + 6) << 5) | (f << (5 - nf)));
    end
  endtask

  function automatic logic [11:0] model(input logic [7:0] p);
    logic [7:0] mag;
    logic       z, n;
    z   = (p == 8'h00);
    n   = (p == 8'h80);
    mag = p[7] ? 8'(8'd0 - p) : p;
    return {p[7], z, n, (z || n) ? 9'd0 : tab[mag[6:0]]};
  endfunction

  function automatic logic [11:0] cur_word();
    return {bus.out_sign, bus.out_zero, bus.out_nar, bus.out_eposit};
  endfunction

  // One clock: drive at negedge, observe settled handshake, score transfers.
  task automatic step(input logic v, input logic [7:0] p, input logic r, input logic rs,
                      output logic acc);
    @(negedge clk);
    rst          = rs;
    bus.in_valid = v;
    bus.in_posit = p;
    bus.out_ready = r;
    #1;
    acc = 1'b0;
    if (held) begin
      check_val("hold_valid", 32'(bus.out_valid), 32'd1);
      check_val("hold_word", 32'(cur_word()), 32'(held_word));
    end
    held = 1'b0;
    if (!rs) begin
      if (bus.in_valid && bus.in_ready) begin
        acc = 1'b1;
        q.push_back(model(p));
        qc.push_back(cyc);
        if (p == 8'h00 && m_zero < (1 << CW) - 1) m_zero++;
        if (p == 8'h80 && m_nar  < (1 << CW) - 1) m_nar++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          check_val("spurious_out", 32'(bus.out_valid), 32'd0);
        end else begin
          logic [11:0] e;
          int          c;
          e = q.pop_front();
          c = qc.pop_front();
          check_val("data", 32'(cur_word()), 32'(e));
          if (lat_chk) check_val("latency", 32'(cyc - c), 32'd2);
        end
      end else if (bus.out_valid) begin
        held      = 1'b1;
        held_word = cur_word();
      end
    end else begin
      q.delete();
      qc.delete();
      m_zero = 0;
      m_nar  = 0;
    end
    cyc++;
  endtask

  task automatic do_reset();
    logic a;
    step(1'b0, 8'h00, 1'b1, 1'b1, a);
    step(1'b0, 8'h00, 1'b1, 1'b1, a);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_val("rst_eposit", 32'(bus.out_eposit), 32'd0);
    cyc++;
  endtask

  task automatic drain();
    logic a;
    for (int i = 0; i < 50 && q.size() != 0; i++) step(1'b0, 8'h00, 1'b1, 1'b0, a);
    check_val("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       a;
    logic [7:0] words [4];
    int         wi;
    bus.in_valid  = 1'b0;
    bus.in_posit  = 8'h00;
    bus.out_ready = 1'b1;
    build_tab();
    check_val("tab_40", 32'(tab[7'h40]), 32'h0C0);
    check_val("tab_50", 32'(tab[7'h50]), 32'h0D0);
    check_val("tab_20", 32'(tab[7'h20]), 32'h0A0);
    check_val("tab_7f", 32'(tab[7'h7F]), 32'h180);
    check_val("tab_01", 32'(tab[7'h01]), 32'h000);

    do_reset();

    // Back-to-back directed words with fixed two-cycle latency.
    lat_chk = 1'b1;
    step(1'b1, 8'h40, 1'b1, 1'b0, a);
    step(1'b1, 8'hC0, 1'b1, 1'b0, a);
    step(1'b1, 8'h50, 1'b1, 1'b0, a);
    step(1'b1, 8'h20, 1'b1, 1'b0, a);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0, a);
    check_val("directed_empty", 32'(q.size()), 32'd0);
    lat_chk = 1'b0;

    // Zero then NaR.
    step(1'b1, 8'h00, 1'b1, 1'b0, a);
    step(1'b1, 8'h80, 1'b1, 1'b0, a);
    drain();
`ifdef POSIT_DECODE_STATS_EN
    check_val("zero_count_1", 32'(zero_count), 32'd1);
    check_val("nar_count_1", 32'(nar_count), 32'd1);
`endif

    // Backpressure: out_ready low on steps 3..7 while four words stream in.
    words[0] = 8'h40; words[1] = 8'h50; words[2] = 8'h20; words[3] = 8'h60;
    wi = 0;
    for (int i = 1; i <= 12; i++) begin
      logic r;
      r = !(i >= 3 && i <= 7);
      step(wi < 4, (wi < 4) ? words[wi] : 8'h00, r, 1'b0, a);
      if (a) wi++;
      if (i == 5) check_val("stall_in_ready", 32'(bus.in_ready), 32'd0);
    end
    drain();
    check_val("stall_all_sent", 32'(wi), 32'd4);

    // Reset with two words in flight; neither may emerge.
    step(1'b1, 8'h40, 1'b0, 1'b0, a);
    step(1'b1, 8'h50, 1'b0, 1'b0, a);
    step(1'b0, 8'h00, 1'b0, 1'b1, a);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check_val("inflight_rst_valid", 32'(bus.out_valid), 32'd0);
    cyc++;
    lat_chk = 1'b1;
    step(1'b1, 8'h40, 1'b1, 1'b0, a);
    drain();
    lat_chk = 1'b0;

    // Random traffic with random stalls.
    for (int i = 0; i < 10000; i++) begin
      logic [7:0] p;
      int         s;
      s = int'($urandom_range(0, 19));
      p = (s == 0) ? 8'h00 : (s == 1) ? 8'h80 : 8'($urandom);
      step(1'($urandom_range(0, 3) != 0), p, 1'($urandom_range(0, 9) < 7), 1'b0, a);
    end
    drain();
`ifdef POSIT_DECODE_STATS_EN
    check_val("rand_zero_count", 32'(zero_count), 32'(m_zero));
    check_val("rand_nar_count", 32'(nar_count), 32'(m_nar));
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 8'h80, 1'b1, 1'b0, a);
    drain();
    check_val("nar_saturate", 32'(nar_count), 32'(m_nar));
    check_val("nar_sat_all_ones", 32'(nar_count), 32'hF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/posit8_decode_pipe.md
Name: posit8_decode_pipe

Overview:
- Pipelined front end for 8-bit posit (es=0) operands. Feeds the team's 8-bit regime shifter, `regimeshifter_with_exp_8bit`, which expects a positive magnitude.
- Accepts raw two's-complement posits over a valid/ready handshake.
- Extracts the sign, takes the absolute value and flags zero and NaR.
- Registers the shifter's 9-bit exponent/fraction word (`eposit`) for the downstream arithmetic stage.
- Two register stages; full throughput under backpressure.

Parameters:
- CNT_WIDTH, 16, width of the optional special-value counters; ignored unless POSIT_DECODE_STATS_EN is defined.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word this cycle.
- in_posit  in  8  raw posit, two's complement.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts a word this cycle.
- out_sign  out  1  posit sign bit (in_posit[7]).
- out_zero  out  1  input was 0x00.
- out_nar  out  1  input was 0x80 (Not-a-Real).
- out_eposit  out  9  [8:4]... precisely: [8:5] biased exponent (regime k + 6), [4:0] fraction, as produced by the regime shifter.

Behaviour:
- Handshake
  - Transfer in on in_valid & in_ready.
  - Transfer out on out_valid & out_ready.
  - out_* is held stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a transfer.
- Stage S1 (v1, sign1, zero1, nar1, mag1[6:0])
  - Load enable: e1 = !v1 | e2.
  - On e1: v1 <= in_valid; payload registered only when in_valid=1.
  - mag1 = in_posit[6:0] if in_posit[7]=0; otherwise (-in_posit)[6:0] (8-bit two's-complement negate).
  - zero1 = (in_posit==0x00); nar1 = (in_posit==0x80).
  - For 0x80, mag1 is forced to 0; the negate would yield 0x80.
- Stage S2 (out_valid, out_*)
  - Load enable: e2 = !out_valid | out_ready.
  - On e2: out_valid <= v1; payload <= {sign1, zero1, nar1, shifter(mag1)}.
  - The shifter receives {1'b0, mag1} and is instantiated once, combinationally, between S1 and S2.
  - When zero1 | nar1, out_eposit is forced to 0 and the shifter output is ignored.
  - For NaR, out_sign = 1.
- in_ready = e1, combinational from out_ready and the valid bits; no path from in_valid.
- Latency: 2 cycles from input transfer to out_valid (no stall).
- Throughput: 1 word/clk with out_ready held high.
- Stall:
  - out_ready=0 with both stages full → in_ready=0 next cycle; both stages hold.
  - Resume: the stage-full word drains first; no loss, duplication or reordering.
- Simultaneous output transfer and input acceptance in the same cycle is legal; both pipeline registers advance together.
- Reset (rst=1 at an edge):
  - v1, out_valid, out_sign, out_zero, out_nar and out_eposit all clear to 0.
  - Any words in flight are discarded.
  - in_ready reads 1 from the first cycle after reset.
  - Reset overrides any handshake in the same cycle.
- Payload registers need not update when the associated valid is 0, except when reset clears them.

Optional Feature:
- Macro: POSIT_DECODE_STATS_EN.
- Defined: adds outputs zero_count[CNT_WIDTH-1:0] and nar_count[CNT_WIDTH-1:0].
  - Each increments by 1 on every input transfer of 0x00 and 0x80 respectively.
  - Both saturate at all-ones, with no wrap.
  - Both clear on rst.
  - Counted at input acceptance, not output.
- Undefined: ports and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then inputs 0x40, 0xC0, 0x50, 0x20 with out_ready=1 on consecutive cycles:
  - Outputs appear 2 cycles after each input transfer, one per cycle.
  - eposit = 0x0C0 sign 0; 0x0C0 sign 1; 0x0D0 sign 0; 0x0A0 sign 0.
- Inputs 0x00 then 0x80:
  - First output: out_zero=1, eposit=0x000, sign=0.
  - Second output: out_nar=1, eposit=0x000, sign=1.
  - With POSIT_DECODE_STATS_EN defined: zero_count=1 and nar_count=1.
- Backpressure: stream 0x40, 0x50, 0x20, 0x60 while out_ready=0 for cycles 3–7:
  - in_ready deasserts once both stages are full; the held output is stable.
  - After release, all four words emerge in order, none duplicated.
- Assert rst for one cycle with two words in flight:
  - out_valid=0 next cycle; neither word ever appears.
  - The next accepted 0x40 yields 0x0C0 after 2 cycles.
- Random stream of 10k words with random in_valid/out_ready, against a reference model → exact in-order match of sign, flags and eposit.
- POSIT_DECODE_STATS_EN defined with CNT_WIDTH=4: send 20 words of 0x80 → nar_count saturates at 0xF.
